// File: rtl/mccpu_pkg.sv
// mccpu_pkg: shared constants for the multi-cycle MIPS controller.
//   Opcode/funct encodings, ALU operation codes, datapath select codes,
//   controller state encoding and a small decode helper.
package mccpu_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes; zero-extended to ALUOP_W at the ports
    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_XOR  = 4'h9;
    localparam logic [3:0] ALU_NOR  = 4'hA;
    localparam logic [3:0] ALU_LUI  = 4'hB;

    // Next-PC, write-data, destination-register and ALU source selects
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MDR  = 2'b01;
    localparam logic [1:0] WD_PC   = 2'b10;
    localparam logic [1:0] WD_LUI  = 2'b11;

    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_31  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

    typedef enum logic [3:0] {
        S_INIT   = 4'h0,
        S_FETCH  = 4'h1,
        S_DECODE = 4'h2,
        S_EXE_R  = 4'h3,
        S_EXE_I  = 4'h4,
        S_MEMADR = 4'h5,
        S_MEMRD  = 4'h6,
        S_MEMWR  = 4'h7,
        S_WB_ALU = 4'h8,
        S_WB_MEM = 4'h9,
        S_BRANCH = 4'hA,
        S_JUMP   = 4'hB,
        S_TRAP   = 4'hC
    } state_e;

    // Shifts take their A operand from shamt rather than rs
    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL);
    endfunction

endpackage

// File: rtl/mccpu_ctrl_if.sv
// mccpu_ctrl_if: controller <-> datapath bundle.
//   master : controller side (consumes op/funct/zero/mem_ready, drives strobes)
//   slave  : datapath/memory side
//   Inputs : op, funct, zero, mem_ready
//   Outputs: pc_write, ir_write, reg_write, mem_read, mem_write, iord, ext_op,
//            alu_op[ALUOP_W], alu_srca, alu_srcb, npc_op, gpr_sel, wd_sel,
//            illegal, retire, state[4]
interface mccpu_ctrl_if #(
    parameter int ALUOP_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               iord;
    logic               ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         alu_srca;
    logic [1:0]         alu_srcb;
    logic [1:0]         npc_op;
    logic [1:0]         gpr_sel;
    logic [1:0]         wd_sel;
    logic               illegal;
    logic               retire;
    logic [3:0]         state;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, iord, ext_op,
               alu_op, alu_srca, alu_srcb, npc_op, gpr_sel, wd_sel,
               illegal, retire, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, iord, ext_op,
               alu_op, alu_srca, alu_srcb, npc_op, gpr_sel, wd_sel,
               illegal, retire, state
    );
endinterface

// File: rtl/mccpu_alu_dec.sv
// mccpu_alu_dec: combinational instruction decode.
//   i_op, i_funct -> o_alu_op (operation for the EXE phase), o_legal
//   (instruction is part of the supported set). ALUOP_W must be >= 4.
module mccpu_alu_dec
    import mccpu_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [5:0]         i_op,
    input  logic [5:0]         i_funct,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_legal
);
    logic [3:0] w_code;

    always_comb begin
        w_code  = ALU_NOP;
        o_legal = 1'b1;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD, FN_ADDU: w_code = ALU_ADD;
                    FN_SUB, FN_SUBU: w_code = ALU_SUB;
                    FN_AND:          w_code = ALU_AND;
                    FN_OR:           w_code = ALU_OR;
                    FN_XOR:          w_code = ALU_XOR;
                    FN_NOR:          w_code = ALU_NOR;
                    FN_SLT:          w_code = ALU_SLT;
                    FN_SLTU:         w_code = ALU_SLTU;
                    FN_SLL:          w_code = ALU_SLL;
                    FN_SRL:          w_code = ALU_SRL;
                    FN_JR:           w_code = ALU_NOP;
                    default:         o_legal = 1'b0;
                endcase
            end
            OP_ADDI:        w_code = ALU_ADD;
            OP_ANDI:        w_code = ALU_AND;
            OP_ORI:         w_code = ALU_OR;
            OP_LUI:         w_code = ALU_LUI;
            OP_LW, OP_SW:   w_code = ALU_ADD;
            OP_BEQ, OP_BNE: w_code = ALU_SUB;
            OP_J, OP_JAL:   w_code = ALU_NOP;
            default:        o_legal = 1'b0;
        endcase
    end

    assign o_alu_op = ALUOP_W'(w_code);
endmodule

// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle MIPS control unit (Moore FSM, outputs decoded from
//   state plus op/funct/zero/mem_ready).
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : mccpu_ctrl_if.master (instruction fields, memory handshake,
//               datapath strobes/selects, illegal, retire, debug state)
//   Optional MCCTRL_PERF_EN: adds PERF_W and cycle_cnt/instr_cnt counters.
module mccpu_ctrl
    import mccpu_pkg::*;
#(
    parameter int ALUOP_W         = 4,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
`ifdef MCCTRL_PERF_EN
    ,
    parameter int PERF_W          = 32
`endif
) (
    input  logic            clk,
    input  logic            rstn,
`ifdef MCCTRL_PERF_EN
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt,
`endif
    mccpu_ctrl_if.master    bus
);
    localparam logic [ALUOP_W-1:0] L_NOP = ALUOP_W'(ALU_NOP);
    localparam logic [ALUOP_W-1:0] L_ADD = ALUOP_W'(ALU_ADD);
    localparam logic [ALUOP_W-1:0] L_SUB = ALUOP_W'(ALU_SUB);

    state_e             r_state, w_next;
    logic [ALUOP_W-1:0] w_dec_alu, w_alu_op;
    logic               w_legal;
    logic               w_pc_write, w_ir_write, w_reg_write;
    logic               w_mem_read, w_mem_write, w_iord, w_ext_op, w_retire;
    logic [1:0]         w_srca, w_srcb, w_npc, w_gpr, w_wd;

    mccpu_alu_dec #(.ALUOP_W(ALUOP_W)) u_alu_dec (
        .i_op     (bus.op),
        .i_funct  (bus.funct),
        .o_alu_op (w_dec_alu),
        .o_legal  (w_legal)
    );

    // Reset forces INIT, whose outputs are all zero, so strobes drop as soon
    // as rstn falls without waiting for a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_INIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        w_ext_op    = 1'b0;
        w_retire    = 1'b0;
        w_alu_op    = L_NOP;
        w_srca      = SRCA_PC;
        w_srcb      = SRCB_RT;
        w_npc       = NPC_PC4;
        w_gpr       = GPR_RD;
        w_wd        = WD_ALU;
        case (r_state)
            S_INIT: w_next = S_FETCH;
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target PC+4 + (imm<<2) lands in ALUOut for BRANCH
                w_srcb   = SRCB_IMMSL2;
                w_alu_op = L_ADD;
                case (bus.op)
                    OP_RTYPE:                       w_next = (bus.funct == FN_JR) ? S_JUMP : S_EXE_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXE_I;
                    OP_LW, OP_SW:                   w_next = S_MEMADR;
                    OP_BEQ, OP_BNE:                 w_next = S_BRANCH;
                    OP_J, OP_JAL:                   w_next = S_JUMP;
                    default:                        w_next = S_TRAP;
                endcase
                // Unknown funct under R-type is also illegal, hence the
                // override after the opcode dispatch.
                if (!w_legal) begin
                    if (TRAP_ON_ILLEGAL) begin
                        w_next = S_TRAP;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_EXE_R: begin
                w_srca   = is_shift(bus.funct) ? SRCA_SHAMT : SRCA_RS;
                w_alu_op = w_dec_alu;
                w_next   = S_WB_ALU;
            end
            S_EXE_I: begin
                // Only addi sign-extends; logical immediates zero-extend
                w_srca   = SRCA_RS;
                w_srcb   = SRCB_IMM;
                w_ext_op = (bus.op == OP_ADDI);
                w_alu_op = w_dec_alu;
                w_next   = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_reg_write = 1'b1;
                w_gpr       = (bus.op == OP_RTYPE) ? GPR_RD : GPR_RT;
                w_wd        = (bus.op == OP_LUI) ? WD_LUI : WD_ALU;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMADR: begin
                w_srca   = SRCA_RS;
                w_srcb   = SRCB_IMM;
                w_ext_op = 1'b1;
                w_alu_op = L_ADD;
                w_next   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) w_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                w_reg_write = 1'b1;
                w_gpr       = GPR_RT;
                w_wd        = WD_MDR;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_srca     = SRCA_RS;
                w_alu_op   = L_SUB;
                w_npc      = NPC_BR;
                w_pc_write = ((bus.op == OP_BEQ) &&  bus.zero) ||
                             ((bus.op == OP_BNE) && !bus.zero);
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                // PC already holds PC+4 from FETCH, which is the jal link value
                w_pc_write = 1'b1;
                w_npc      = (bus.op == OP_RTYPE) ? NPC_JR : NPC_J;
                if (bus.op == OP_JAL) begin
                    w_reg_write = 1'b1;
                    w_gpr       = GPR_31;
                    w_wd        = WD_PC;
                end
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_INIT;
        endcase
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.ir_write  = w_ir_write;
    assign bus.reg_write = w_reg_write;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.iord      = w_iord;
    assign bus.ext_op    = w_ext_op;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_srca  = w_srca;
    assign bus.alu_srcb  = w_srcb;
    assign bus.npc_op    = w_npc;
    assign bus.gpr_sel   = w_gpr;
    assign bus.wd_sel    = w_wd;
    assign bus.retire    = w_retire;
    // TRAP only exits through reset, so the flag is sticky by construction
    assign bus.illegal   = (r_state == S_TRAP);
    assign bus.state     = r_state;

`ifdef MCCTRL_PERF_EN
    logic [PERF_W-1:0] r_cycle_cnt, r_instr_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_INIT && r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + PERF_W'(1);
            if (w_retire)                               r_instr_cnt <= r_instr_cnt + PERF_W'(1);
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif
endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb_mccpu_ctrl: randomized instruction stream against a per-instruction
//   reference model (expected length, strobe counts and selects derived from
//   the instruction class and the stall counts the bench injects).
//   u_dut traps on illegal opcodes; u_dut2 treats them as NOPs.
module tb_mccpu_ctrl;
    import mccpu_pkg::*;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5;

    typedef struct {
        string      nm;
        logic [5:0] op;
        int         fn;     // -1: funct is don't-care, randomized
        int         kind;
        int         alu;    // ALU code expected in the cycle after DECODE
    } ins_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ins_t tbl[$];

    mccpu_ctrl_if #(.ALUOP_W(4)) bus ();
    mccpu_ctrl_if #(.ALUOP_W(4)) bus2 ();

    assign bus2.op        = bus.op;
    assign bus2.funct     = bus.funct;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;

`ifdef MCCTRL_PERF_EN
    logic [31:0] cyc1, ins1, cyc2, ins2;
`endif

    mccpu_ctrl #(.ALUOP_W(4), .TRAP_ON_ILLEGAL(1'b1)) u_dut (
        .clk  (clk),
        .rstn (rstn),
`ifdef MCCTRL_PERF_EN
        .cycle_cnt (cyc1),
        .instr_cnt (ins1),
`endif
        .bus  (bus.master)
    );

    mccpu_ctrl #(.ALUOP_W(4), .TRAP_ON_ILLEGAL(1'b0)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
`ifdef MCCTRL_PERF_EN
        .cycle_cnt (cyc2),
        .instr_cnt (ins2),
`endif
        .bus  (bus2.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int find(input string nm);
        foreach (tbl[i]) if (tbl[i].nm == nm) return i;
        return 0;
    endfunction

    function automatic int strobes1();
        return int'(bus.pc_write | bus.ir_write | bus.reg_write |
                    bus.mem_read | bus.mem_write | bus.retire);
    endfunction

    // Leaves the bench #1 after the edge that moves INIT -> FETCH
    task automatic do_reset(input string tag);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".state"},   int'(bus.state), int'(S_INIT));
        chk({tag, ".illegal"}, int'(bus.illegal), 0);
        chk({tag, ".strobes"}, strobes1(), 0);
        chk({tag, ".illegal2"}, int'(bus2.illegal), 0);
        @(negedge clk);
        rstn          = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // f: FETCH stall cycles, m: MEMRD/MEMWR stall cycles
    task automatic run_ins(input int idx, input logic z, input int f, input int m);
        ins_t t;
        logic [5:0] fn;
        int  cyc, ret_cyc, n_ret, n_irw, irw_cyc, n_rw, rw_gpr, rw_wd;
        int  n_pcw, last_npc, n_mr, n_mw, n_both, bad_iord;
        int  dec_alu, dec_srcb, exe_alu, exe_srca, exe_srcb, exe_ext;
        int  e_last, e_nrw, e_gpr, e_wd, e_npcw, e_npc, e_nmr, e_nmw;
        int  e_srca, e_srcb, e_ext;
        bit  mem, taken, is_jr, done;
        t   = tbl[idx];
        fn  = (t.fn < 0) ? 6'($urandom_range(0, 63)) : 6'(t.fn);
        mem = (t.kind == K_LW) || (t.kind == K_SW);
        taken = (t.op == 6'h04 && z) || (t.op == 6'h05 && !z);
        is_jr = (t.kind == K_J) && (t.op == 6'h00);

        // reference model
        e_nrw = 0; e_gpr = 0; e_wd = 0; e_last = f + 2;
        case (t.kind)
            K_R:  begin e_last = f + 3;     e_nrw = 1; e_gpr = 0; e_wd = 0; end
            K_I:  begin e_last = f + 3;     e_nrw = 1; e_gpr = 1; e_wd = (t.op == 6'h0F) ? 3 : 0; end
            K_LW: begin e_last = f + m + 4; e_nrw = 1; e_gpr = 1; e_wd = 1; end
            K_SW: begin e_last = f + m + 3; end
            K_BR: begin e_last = f + 2; end
            default: begin e_last = f + 2; e_nrw = (t.op == 6'h03) ? 1 : 0; e_gpr = 2; e_wd = 2; end
        endcase
        e_npcw = 1 + int'(taken) + ((t.kind == K_J) ? 1 : 0);
        e_npc  = (t.kind == K_J) ? (is_jr ? 3 : 2) : (taken ? 1 : 0);
        e_nmr  = f + 1 + ((t.kind == K_LW) ? m + 1 : 0);
        e_nmw  = (t.kind == K_SW) ? m + 1 : 0;
        e_srca = (t.kind == K_R && (fn == 6'h00 || fn == 6'h02)) ? 2 : 1;
        e_srcb = (t.kind == K_R || t.kind == K_BR) ? 0 : 2;
        e_ext  = ((t.kind == K_I && t.op == 6'h08) || mem) ? 1 : 0;

        bus.op = t.op; bus.funct = fn; bus.zero = z;
        cyc = 0; done = 0; ret_cyc = -1; n_ret = 0; n_irw = 0; irw_cyc = -1;
        n_rw = 0; rw_gpr = -1; rw_wd = -1; n_pcw = 0; last_npc = -1;
        n_mr = 0; n_mw = 0; n_both = 0; bad_iord = 0;
        dec_alu = -1; dec_srcb = -1; exe_alu = -1; exe_srca = -1; exe_srcb = -1; exe_ext = -1;
        while (!done && cyc < 64) begin
            bus.mem_ready = !((cyc < f) || (mem && cyc >= f + 3 && cyc < f + 3 + m));
            @(negedge clk);
            if (bus.retire)    begin n_ret++; ret_cyc = cyc; done = 1; end
            if (bus.ir_write)  begin n_irw++; irw_cyc = cyc; end
            if (bus.reg_write) begin n_rw++; rw_gpr = int'(bus.gpr_sel); rw_wd = int'(bus.wd_sel); end
            if (bus.pc_write)  begin n_pcw++; last_npc = int'(bus.npc_op); end
            if (bus.mem_read)  n_mr++;
            if (bus.mem_write) n_mw++;
            if (bus.mem_read && bus.mem_write) n_both++;
            if (bus.mem_write && !bus.iord) bad_iord++;
            if (bus.mem_read && (bus.iord != (cyc > f))) bad_iord++;
            if (cyc == f + 1) begin dec_alu = int'(bus.alu_op); dec_srcb = int'(bus.alu_srcb); end
            if (cyc == f + 2) begin
                exe_alu = int'(bus.alu_op); exe_srca = int'(bus.alu_srca);
                exe_srcb = int'(bus.alu_srcb); exe_ext = int'(bus.ext_op);
            end
            @(posedge clk);
            #1;
            cyc++;
        end

        chk({t.nm, ".retire_cycle"}, ret_cyc, e_last);
        chk({t.nm, ".n_retire"},     n_ret, 1);
        chk({t.nm, ".ir_write_cyc"}, irw_cyc, f);
        chk({t.nm, ".n_ir_write"},   n_irw, 1);
        chk({t.nm, ".n_reg_write"},  n_rw, e_nrw);
        if (e_nrw == 1) begin
            chk({t.nm, ".gpr_sel"}, rw_gpr, e_gpr);
            chk({t.nm, ".wd_sel"},  rw_wd, e_wd);
        end
        chk({t.nm, ".n_pc_write"},   n_pcw, e_npcw);
        chk({t.nm, ".last_npc_op"},  last_npc, e_npc);
        chk({t.nm, ".n_mem_read"},   n_mr, e_nmr);
        chk({t.nm, ".n_mem_write"},  n_mw, e_nmw);
        chk({t.nm, ".rd_wr_both"},   n_both, 0);
        chk({t.nm, ".iord"},         bad_iord, 0);
        chk({t.nm, ".dec_alu"},      dec_alu, 1);
        chk({t.nm, ".dec_srcb"},     dec_srcb, 3);
        if (t.kind != K_J) begin
            chk({t.nm, ".exe_alu"},  exe_alu, t.alu);
            chk({t.nm, ".exe_srca"}, exe_srca, e_srca);
            chk({t.nm, ".exe_srcb"}, exe_srcb, e_srcb);
            chk({t.nm, ".exe_ext"},  exe_ext, e_ext);
        end
    endtask

    initial begin
        int n_ill_low, n_strb, n_notrap;
        tbl.push_back('{"addu", 6'h00, 'h21, K_R, 1});
        tbl.push_back('{"add",  6'h00, 'h20, K_R, 1});
        tbl.push_back('{"subu", 6'h00, 'h23, K_R, 2});
        tbl.push_back('{"sub",  6'h00, 'h22, K_R, 2});
        tbl.push_back('{"and",  6'h00, 'h24, K_R, 3});
        tbl.push_back('{"or",   6'h00, 'h25, K_R, 4});
        tbl.push_back('{"xor",  6'h00, 'h26, K_R, 9});
        tbl.push_back('{"nor",  6'h00, 'h27, K_R, 10});
        tbl.push_back('{"slt",  6'h00, 'h2A, K_R, 5});
        tbl.push_back('{"sltu", 6'h00, 'h2B, K_R, 6});
        tbl.push_back('{"sll",  6'h00, 'h00, K_R, 7});
        tbl.push_back('{"srl",  6'h00, 'h02, K_R, 8});
        tbl.push_back('{"addi", 6'h08, -1,   K_I, 1});
        tbl.push_back('{"andi", 6'h0C, -1,   K_I, 3});
        tbl.push_back('{"ori",  6'h0D, -1,   K_I, 4});
        tbl.push_back('{"lui",  6'h0F, -1,   K_I, 11});
        tbl.push_back('{"lw",   6'h23, -1,   K_LW, 1});
        tbl.push_back('{"sw",   6'h2B, -1,   K_SW, 1});
        tbl.push_back('{"beq",  6'h04, -1,   K_BR, 2});
        tbl.push_back('{"bne",  6'h05, -1,   K_BR, 2});
        tbl.push_back('{"j",    6'h02, -1,   K_J, 0});
        tbl.push_back('{"jal",  6'h03, -1,   K_J, 0});
        tbl.push_back('{"jr",   6'h00, 'h08, K_J, 0});

        bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        do_reset("reset0");

        // directed
        run_ins(find("addu"), 1'b0, 0, 0);
        run_ins(find("lw"),   1'b0, 2, 2);
        run_ins(find("beq"),  1'b1, 0, 0);
        run_ins(find("bne"),  1'b1, 0, 0);
        run_ins(find("jal"),  1'b0, 1, 0);
        run_ins(find("jr"),   1'b0, 0, 0);
        run_ins(find("sw"),   1'b0, 1, 3);

        // random stream
        for (int i = 0; i < 80; i++)
            run_ins($urandom_range(0, tbl.size() - 1), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));

        // reset while MEMWR is waiting on mem_ready
        bus.op = 6'h2B; bus.funct = 6'h00; bus.zero = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_ready = (c == 0);
            @(negedge clk);
            if (c == 5) chk("rst_mw.mem_write_before", int'(bus.mem_write), 1);
            else begin @(posedge clk); #1; end
        end
        #2 rstn = 1'b0;
        #1;
        chk("rst_mw.mem_write_after", int'(bus.mem_write), 0);
        chk("rst_mw.state",           int'(bus.state), int'(S_INIT));
        chk("rst_mw.illegal",         int'(bus.illegal), 0);
        do_reset("reset1");
        run_ins(find("or"), 1'b0, 0, 0);

        // illegal opcode: u_dut traps, u_dut2 retires as a NOP
        bus.op = 6'h3F; bus.funct = 6'($urandom_range(0, 63)); bus.mem_ready = 1'b1;
        n_ill_low = 0; n_strb = 0; n_notrap = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("ill.trap_retire", int'(bus.retire), 0);
                chk("ill.nop_retire",  int'(bus2.retire), 1);
            end
            if (c == 2) chk("ill.nop_fetch", int'(bus2.state), int'(S_FETCH));
            if (c >= 2) begin
                if (!bus.illegal) n_ill_low++;
                if (strobes1() != 0) n_strb++;
                if (bus.state != 4'(S_TRAP)) n_notrap++;
            end
            @(posedge clk);
            #1;
        end
        chk("ill.sticky",     n_ill_low, 0);
        chk("ill.no_strobes", n_strb, 0);
        chk("ill.stays_trap", n_notrap, 0);

        do_reset("reset2");
        run_ins(find("addi"), 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mccpu_ctrl.md
Name: mccpu_ctrl

Overview:
Multi-cycle MIPS control unit: Moore-style FSM sequencing each instruction through fetch, decode, execute, memory and writeback. Generalised successor to the single-cycle decoder, with a wider instruction set (xor/nor/srl/andi/bne/jal/jr), parametrised ALU-op width and variable-latency memory via a ready handshake. Sits beside the shared datapath (PC, IR, RF, ALU, ALUOut, MDR) in the MCCPU top.

Parameters:
ALUOP_W, 4, ALU operation code width (min 4)
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode enters sticky TRAP; 0 = executes as NOP
PERF_W, 32, width of perf counters (used only with MCCTRL_PERF_EN)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
op  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
reg_write  out  1  register file write
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0 = address from PC, 1 = from ALUOut
ext_op  out  1  1 = sign extend immediate
alu_op  out  ALUOP_W  ALU operation
alu_srca  out  2  00 PC, 01 rs, 10 shamt
alu_srcb  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
npc_op  out  2  00 PC+4, 01 branch, 10 jump, 11 jr (rs)
gpr_sel  out  2  00 rd, 01 rt, 10 $31
wd_sel  out  2  00 ALUOut, 01 MDR, 10 PC, 11 imm<<16 (lui)
illegal  out  1  sticky illegal-instruction flag
retire  out  1  one-cycle pulse on final cycle of each instruction
state  out  4  current state, for debug

Behaviour:
- Clock clk; reset asynchronous, active-low (rstn). Reset -> state S_INIT; illegal=0; all strobes/selects 0. S_INIT lasts one cycle, then S_FETCH.
- States: INIT, FETCH, DECODE, EXE_R, EXE_I, MEMADR, MEMRD, MEMWR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- FETCH: mem_read=1, iord=0; hold until mem_ready; in ready cycle ir_write=1, pc_write=1, npc_op=00 -> DECODE.
- DECODE: alu_srca=00, alu_srcb=11, alu_op=ADD (branch target to ALUOut). Next: R-type (excl. jr) -> EXE_R; addi/andi/ori/lui -> EXE_I; lw/sw -> MEMADR; beq/bne -> BRANCH; j/jal/jr -> JUMP; else TRAP (or FETCH with retire=1 if TRAP_ON_ILLEGAL=0).
- EXE_R: srca=01 (10 for sll/srl), srcb=00, alu_op from funct -> WB_ALU. EXE_I: srca=01, srcb=10, ext_op=1 only for addi -> WB_ALU.
- WB_ALU: reg_write=1, gpr_sel=00 (R) / 01 (I), wd_sel=00 (11 for lui); retire=1 -> FETCH.
- MEMADR: srca=01, srcb=10, ext_op=1, alu_op=ADD -> MEMRD (lw) / MEMWR (sw).
- MEMRD: mem_read=1, iord=1, wait mem_ready -> WB_MEM. WB_MEM: reg_write, gpr_sel=01, wd_sel=01, retire -> FETCH.
- MEMWR: mem_write=1, iord=1, wait mem_ready; retire in ready cycle -> FETCH.
- BRANCH: srca=01, srcb=00, alu_op=SUB; npc_op=01; pc_write=(beq&zero)|(bne&~zero); retire -> FETCH.
- JUMP: pc_write=1, npc_op=10 (j/jal) or 11 (jr); jal: reg_write=1, gpr_sel=10, wd_sel=10 (PC already +4); retire -> FETCH.
- TRAP: absorbing; illegal=1; no strobes; exits only on reset.
- Outputs combinational from state, op, funct, zero; state is the only mandatory register. mem_read/mem_write held stable while waiting; never both high.
- Reset mid-operation aborts immediately; no write strobe asserted after rstn falls.

Optional Feature:
MCCTRL_PERF_EN: adds outputs cycle_cnt and instr_cnt (PERF_W each), cleared on reset; cycle_cnt increments every cycle outside INIT/TRAP, instr_cnt on retire; both wrap modulo 2^PERF_W. Without the macro, ports and logic absent.

Decomposition:
- Package mccpu_pkg: opcode/funct constants, ALU_* codes (NOP0 ADD1 SUB2 AND3 OR4 SLT5 SLTU6 SLL7 SRL8 XOR9 NORA LUIB), NPC_*, WD_*, GPR_*, state encodings.
- Sub-module mccpu_alu_dec: combinational (op, funct) -> alu_op and legal flag.

Test Plan:
- rstn release, addu with mem_ready=1 -> INIT, then FETCH/DECODE/EXE_R/WB_ALU; retire in 4th cycle, reg_write=1, gpr_sel=00.
- lw with mem_ready low 2 cycles in FETCH and MEMRD -> mem_read held, ir_write only in ready cycle, total 9 cycles, wd_sel=01.
- beq zero=1 then bne zero=1 -> pc_write=1 with npc_op=01 first; pc_write=0 second.
- jal -> JUMP: pc_write=1, npc_op=10, reg_write=1, gpr_sel=10, wd_sel=10; jr -> npc_op=11, reg_write=0.
- op=6'h3F -> TRAP, illegal=1 sticky, no strobes for 20 cycles; TRAP_ON_ILLEGAL=0 -> retire, back to FETCH.
- rstn low during MEMWR wait -> mem_write drops asynchronously, state=INIT, illegal=0.
